// File: rtl/vga_timing_gen.sv
// Raster timing source: free-running pixel/line counters, sync and
// display-enable decode, a matched delay line, and frame/line strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       blank_d,
    output logic       hs_d,
    output logic       vs_d,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] X_HS0  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] X_HS1  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] Y_VS0  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] Y_VS1  = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line reset word, ordered {blank, hs, vs}: blanked, syncs idle
    localparam logic [2:0] PIPE_RST = {1'b0, ~SYNC_POL, ~SYNC_POL};

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [7:0] r_fc;
    logic [2:0] r_pipe [PIPE_DLY];

    logic       w_blank;
    logic       w_hs;
    logic       w_vs;
    logic [2:0] w_now;

    // Pixel/line counters; line and frame wrap share the (last,last) edge
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_x  <= '0;
            r_y  <= '0;
            r_fc <= '0;
        end else if (r_x == X_LAST) begin
            r_x <= '0;
            if (r_y == Y_LAST) begin
                r_y  <= '0;
                r_fc <= r_fc + 8'd1;
            end else begin
                r_y <= r_y + 10'd1;
            end
        end else begin
            r_x <= r_x + 10'd1;
        end
    end

    // Zero-latency decode straight off the counter registers
    always_comb begin
        w_blank = (r_x < X_ACT) && (r_y < Y_ACT);
        w_hs    = ~SYNC_POL;
        w_vs    = ~SYNC_POL;
        if ((r_x >= X_HS0) && (r_x < X_HS1)) begin
            w_hs = SYNC_POL;
        end
        if ((r_y >= Y_VS0) && (r_y < Y_VS1)) begin
            w_vs = SYNC_POL;
        end
        w_now = {w_blank, w_hs, w_vs};
    end

    // Shift register matching renderer latency on blank/hs/vs
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DLY; i++) begin
                r_pipe[i] <= PIPE_RST;
            end
        end else begin
            r_pipe[0] <= w_now;
            for (int i = 1; i < PIPE_DLY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign DrawX       = r_x;
    assign DrawY       = r_y;
    assign blank       = w_blank;
    assign hs          = w_hs;
    assign vs          = w_vs;
    assign blank_d     = r_pipe[PIPE_DLY-1][2];
    assign hs_d        = r_pipe[PIPE_DLY-1][1];
    assign vs_d        = r_pipe[PIPE_DLY-1][0];
    assign line_start  = (r_x == 10'd0);
    assign frame_start = (r_x == 10'd0) && (r_y == 10'd0);
    assign frame_count = r_fc;

endmodule
